// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, defaults and width helpers for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int c_DATASIZE_DEF = 8;
    localparam int c_NREQ_DEF     = 4;
    localparam int c_BURST_DEF    = 4;

    // Width of a requester index; requester counts are always >= 2.
    function automatic int gnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Burst counter must be able to hold the value BURST itself.
    function automatic int cnt_width(input int b);
        return (b < 1) ? 1 : $clog2(b + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first valid after i_last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEF,
    parameter int GW   = gnt_width(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [GW-1:0]   i_last,
    output logic [GW-1:0]   o_pick,
    output logic            o_any
);

    logic [GW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest candidate after i_last wins.
    always_comb begin
        o_pick = '0;
        o_any  = 1'b0;
        w_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = GW'((int'(i_last) + k) % NREQ);
            if (i_valid[w_idx]) begin
                o_pick = w_idx;
                o_any  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-bounded arbiter sharing one FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATASIZE = c_DATASIZE_DEF,
    parameter int NREQ     = c_NREQ_DEF,
    parameter int BURST    = c_BURST_DEF
) (
    input  logic                     wclk,
    input  logic                     w_rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int c_GW = gnt_width(NREQ);
    localparam int c_CW = cnt_width(BURST);

    state_t          r_state;
    logic [c_GW-1:0] r_gnt;
    logic [c_GW-1:0] r_last_gnt;
    logic [c_CW-1:0] r_cnt;

    logic            w_grant;
    logic            w_hold_valid;
    logic            w_winc;
    logic            w_burst_done;
    logic            w_release;
    logic [c_GW-1:0] w_pick_last;
    logic [c_GW-1:0] w_pick;
    logic            w_any;

    assign w_grant      = (r_state == GRANT);
    assign w_hold_valid = req_valid[r_gnt];
    assign w_winc       = w_grant & w_hold_valid & ~wfull;
    assign w_burst_done = w_winc & (r_cnt == c_CW'(BURST - 1));
    // A full FIFO freezes the grant; it never forces a release.
    assign w_release    = w_grant & ~wfull & (w_burst_done | ~w_hold_valid);

    // In GRANT the rotation starts after the current holder, in IDLE after the last one.
    assign w_pick_last  = w_grant ? r_gnt : r_last_gnt;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (c_GW)
    ) u_pick (
        .i_valid (req_valid),
        .i_last  (w_pick_last),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    always_comb begin
        req_ready = '0;
        if (w_grant && !wfull) begin
            req_ready[r_gnt] = 1'b1;
        end
    end

    assign winc     = w_winc;
    assign wdata    = w_winc ? req_data[int'(r_gnt)*DATASIZE +: DATASIZE] : '0;
    assign grant_id = r_gnt;
    assign busy     = w_grant;

    always_ff @(posedge wclk or negedge w_rst) begin
        if (!w_rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_last_gnt <= c_GW'(NREQ - 1);
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= w_pick;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last_gnt <= r_gnt;
                        r_cnt      <= '0;
                        if (w_any) begin
                            r_gnt <= w_pick;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_winc) begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the async FIFO. It shares the FIFO's single write port (winc/wdata, gated by wfull) between NREQ producers in the wclk domain. Each grant is held for a bounded burst of up to BURST words, then priority rotates. The block sits between the producer agents and the FIFO write interface inside top. The read side is untouched.

Parameters:
DATASIZE, 8, FIFO word width; must match the FIFO's DATASIZE.
NREQ, 4, number of requesters; legal range 2..16.
BURST, 4, maximum words per grant; legal range 1..256.

Ports:
wclk  input  1  write-domain clock; all state updates on the rising edge.
w_rst  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester data valid.
req_data  input  NREQ*DATASIZE  packed data; requester i occupies bits [i*DATASIZE +: DATASIZE].
req_ready  output  NREQ  per-requester accept; transfer when valid and ready are both high.
wfull  input  1  FIFO full flag, already in the wclk domain.
winc  output  1  FIFO write enable.
wdata  output  DATASIZE  FIFO write data.
grant_id  output  $clog2(NREQ)  index of the current grant holder.
busy  output  1  high while in GRANT.

Behaviour:
- State machine with two states, IDLE and GRANT. Registers: state, gnt (grant_id), last_gnt, cnt ($clog2(BURST+1) bits).
- Reset values (asynchronous on w_rst low):
  - state=IDLE, gnt=0, last_gnt=NREQ-1, cnt=0.
  - Outputs winc=0, req_ready=0, busy=0, grant_id=0, wdata=0.
  - These take effect immediately, even mid-burst. A word not yet accepted is not written.
- Pick function: the first i with req_valid[i] set, searching from (last_gnt+1) mod NREQ upward with wrap-around.
- IDLE:
  - If any req_valid is set, go to GRANT at the next edge with gnt=pick, cnt=0.
  - Otherwise stay in IDLE.
  - This gives one cycle of arbitration latency from IDLE.
- GRANT, combinational outputs with zero latency to the FIFO:
  - req_ready[gnt] = !wfull. All other req_ready bits are 0.
  - winc = req_valid[gnt] & !wfull.
  - wdata = req_data[gnt]. When winc=0, wdata is 0.
- GRANT, per edge:
  - If winc is high, cnt increments.
  - While wfull is high, cnt and gnt are frozen, and winc and req_ready are 0. The grant is never released because of wfull.
- Release happens when either:
  - (winc && cnt==BURST-1), or
  - req_valid[gnt]==0.
- On release:
  - last_gnt<=gnt and cnt<=0.
  - The next grant is picked in the same edge, using the rotated priority starting after the old gnt. The old holder is eligible only if no other requester is valid.
  - If no requester is valid, go to IDLE.
  - Back-to-back grants therefore have no bubble cycle.
- Requester rule: req_valid and req_data are held stable until accepted. A requester that drops valid forfeits its grant at the next edge.
- grant_id and busy are registered, so they reflect state directly.
- Exactly one word is written per winc cycle. No word is duplicated, and no word is written while wfull is high.

Decomposition:
- Shared package fifo_arb_pkg:
  - state typedef (IDLE, GRANT).
  - Localparams for grant width $clog2(NREQ) and count width.
- One sub-module, rr_pick: purely combinational. Inputs are the valid vector and last_gnt; outputs are the pick index and an any-valid flag. It is reused by the IDLE and release paths.

Test Plan:
1. Only req 0 valid with words 0xA0, 0xA1, 0xA2, wfull=0 -> grant_id=0 one cycle after valid. winc high for 3 consecutive cycles with wdata A0, A1, A2. Return to IDLE with busy=0 the cycle after req_valid drops.
2. All 4 requesters continuously valid, BURST=4 -> grants in order 0,1,2,3,0. Exactly 4 winc per grant. No idle cycle between grants. 16 writes in 16 cycles after the first grant.
3. Req 1 granted; wfull asserted after 2 words and held for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles; grant_id stays 1. After wfull drops, 2 more words are written and the grant then rotates. Total written is 4, with none during full.
4. Req 2 granted, drops valid after 2 words; req 3 valid -> grant_id=3 at the next edge with no bubble. Req 2 has only 2 writes recorded.
5. w_rst low asynchronously mid-burst -> winc, req_ready and busy go to 0 in the same cycle, grant_id=0. After release with reqs 1 and 3 valid -> grant 1 first.
6. Last grant was 3; reqs 0 and 3 both valid -> grant 0. After release with only req 3 still valid -> grant 3.
